data_mem_arbiter: RTL

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 76 +++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port (core LSU / debug loader) data memory arbiter with B-starvation guard
module data_mem_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_A_Req,
  input  logic        i_A_Write,
  input  logic [2:0]  i_A_Mode,
  input  logic [31:0] i_A_Address,
  input  logic [31:0] i_A_DataIn,
  input  logic        i_B_Req,
  input  logic        i_B_Write,
  input  logic [2:0]  i_B_Mode,
  input  logic [31:0] i_B_Address,
  input  logic [31:0] i_B_DataIn,
  output logic        o_A_Grant,
  output logic        o_A_RespValid,
  output logic [31:0] o_A_RespData,
  output logic        o_A_RespError,
  output logic        o_B_Grant,
  output logic        o_B_RespValid,
  output logic [31:0] o_B_RespData,
  output logic        o_B_RespError,
  output logic        o_Mem_WriteEnable,
  output logic        o_Mem_ReadEnable,
  output logic [2:0]  o_Mem_Mode,
  output logic [31:0] o_Mem_Address,
  output logic [31:0] o_Mem_DataIn,
  input  logic [31:0] i_Mem_DataOut,
  input  logic        i_Mem_MisalignedAccess
);
  logic [3:0] starve_count;
  logic resp_valid, resp_owner, resp_is_read, resp_error;
  logic pick_b, grant_a, grant_b, granted, sel_write, mis;
  logic [2:0] sel_mode;
  logic [31:0] sel_addr, sel_data;
  assign pick_b = i_B_Req & (~i_A_Req | (starve_count == 4'(STARVE_LIMIT)));
  assign grant_b = ~i_Reset & pick_b;
  assign grant_a = ~i_Reset & i_A_Req & ~pick_b;
  assign granted = grant_a | grant_b;
  assign o_A_Grant = grant_a;
  assign o_B_Grant = grant_b;
  assign sel_write = grant_b ? i_B_Write : i_A_Write;
  assign sel_mode = grant_b ? i_B_Mode : i_A_Mode;
  assign sel_addr = grant_b ? i_B_Address : i_A_Address;
  assign sel_data = grant_b ? i_B_DataIn : i_A_DataIn;
  // mode[1:0] distinguishes byte/half/word for both signed and unsigned loads
  assign mis = ((sel_mode[1:0] == 2'b01) & sel_addr[0]) | ((sel_mode[1:0] == 2'b10) & (sel_addr[1:0] != 2'b00));
  assign o_Mem_ReadEnable = granted & ~sel_write;
  assign o_Mem_WriteEnable = granted & sel_write & ~mis;
  assign o_Mem_Mode = granted ? sel_mode : 3'd0;
  assign o_Mem_Address = granted ? sel_addr : 32'd0;
  assign o_Mem_DataIn = granted ? sel_data : 32'd0;
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      starve_count <= 4'd0;
      resp_valid <= 1'b0;
      resp_owner <= 1'b0;
      resp_is_read <= 1'b0;
      resp_error <= 1'b0;
    end else begin
      starve_count <= (i_B_Req & ~grant_b) ? starve_count + 4'd1 : 4'd0;
      resp_valid <= granted;
      resp_owner <= grant_b;
      resp_is_read <= granted & ~sel_write;
      resp_error <= granted & (sel_write ? mis : i_Mem_MisalignedAccess);
    end
  end
  assign o_A_RespValid = resp_valid & ~resp_owner;
  assign o_B_RespValid = resp_valid & resp_owner;
  assign o_A_RespError = o_A_RespValid & resp_error;
  assign o_B_RespError = o_B_RespValid & resp_error;
  assign o_A_RespData = (o_A_RespValid & resp_is_read & ~resp_error) ? i_Mem_DataOut : 32'd0;
  assign o_B_RespData = (o_B_RespValid & resp_is_read & ~resp_error) ? i_Mem_DataOut : 32'd0;
endmodule
